ram_access_controller: RTL and testbench
========================================

# ram_access_controller

Front-end controller for the 8×8 `single_port_ram`. It sits directly upstream of the RAM and owns all four RAM control inputs. It zero-fills the array after reset, then arbitrates independent write and read request channels onto the single port with valid/ready handshakes. Read data comes back on a response channel with fixed latency.

## Interface
- `DATA_W`, default 8: data width; matches RAM `data_in`/`data_out`.
- `ADDR_W`, default 3: address width. Depth is `DEPTH = 2**ADDR_W` (derived, not a parameter).

Ports (name, direction, width, meaning):
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_valid`  in  1  write request present.
- `wr_ready`  out  1  write request accepted this cycle.
- `wr_addr`  in  ADDR_W  write address.
- `wr_data`  in  DATA_W  write data.
- `rd_valid`  in  1  read request present.
- `rd_ready`  out  1  read request accepted this cycle.
- `rd_addr`  in  ADDR_W  read address.
- `rsp_valid`  out  1  read response valid. No backpressure on this channel.
- `rsp_data`  out  DATA_W  read response data. Equals 0 when `rsp_valid` is low.
- `init_done`  out  1  zero-fill complete; the request channels are live.
- `ram_en`, `ram_we`  out  1  connect to RAM `en`, `we`.
- `ram_addr`  out  ADDR_W  connects to RAM `address`.
- `ram_wdata`  out  DATA_W  connects to RAM `data_in`.
- `ram_rdata`  in  DATA_W  connects to RAM `data_out`.

## Operation
- RAM contract:
  - Synchronous write: at a rising edge with `en=1` and `we=1`, the RAM writes `data_in` to `address`.
  - Synchronous read: at a rising edge with `en=1` and `we=0`, the RAM updates `data_out`.
- FSM, two states, `INIT` and `RUN`. Reset forces `INIT` with the sweep counter at 0.
- `INIT`:
  - Drives `ram_en=1`, `ram_we=1`, `ram_addr=counter`, `ram_wdata=0`.
  - The counter increments every cycle.
  - After the write to `DEPTH-1`, the FSM moves to `RUN`.
  - `wr_ready` and `rd_ready` are 0 throughout.
- `RUN`: at most one RAM access per cycle, selected as follows.
  - Only `wr_valid` high: grant write.
  - Only `rd_valid` high: grant read.
  - Both high: grant the channel not granted in the most recent contested cycle. The round-robin bit resets to favour write and updates only on contested cycles.
  - Neither high: `ram_en=0`.
- Control outputs are combinational from the grant:
  - `ready` is high only on the granted channel.
  - `ram_en=1`; `ram_we=1` for write, 0 for read.
  - `ram_addr` and `ram_wdata` come from the granted channel.
  - `ram_wdata=0` on reads.
- Requesters may drop `valid` without a handshake; requests are not latched.
- Ordering is strictly issue order, so a read granted after a write to the same address returns the new data.
- Reset mid-operation (asynchronous):
  - Immediately forces `rsp_valid=0`, `init_done=0`, both readies 0 and all `ram_*` outputs 0.
  - Any in-flight response is dropped.
  - On release, the zero-fill restarts at address 0, so prior contents are cleared.

## Timing
- Reset values: `rsp_valid=0`, `rsp_data=0`, `init_done=0`, `wr_ready=0`, `rd_ready=0`, `ram_en=0`, `ram_we=0`, `ram_addr=0`, `ram_wdata=0`.
- Zero-fill: the first sweep write happens at the first rising edge after `rst_n` deasserts. The sweep occupies edges 1..DEPTH.
- `init_done` is a registered output and goes high after edge DEPTH (8 for defaults). It stays high until the next reset.
- Read latency is 1 cycle:
  - A read handshake at edge N makes `rsp_valid` high for exactly the cycle after edge N.
  - During that cycle, `rsp_data=ram_rdata`.
- Back-to-back reads give `rsp_valid` high on consecutive cycles, with full throughput of 1 access per cycle.
- Writes produce no response and complete at their handshake edge.

## Structure
- Shared package `ram_ctrl_pkg` holds:
  - the `DATA_W` and `ADDR_W` defaults;
  - the `ctrl_state_t` enum (`INIT`, `RUN`);
  - the grant encoding constants (`GNT_NONE`, `GNT_WR`, `GNT_RD`).
- One sub-module, `rr_arbiter2`: a two-requester round-robin arbiter with one-hot grant output and an internal priority bit updated on contested grants.
- The top level holds the FSM, sweep counter, response flag and output muxing.

## Test plan
- Reset release, no requests: check `ram_we=1` on addresses 0..7 with data 00 over 8 cycles and `init_done` rising after edge 8; then read address 5 and expect `rsp_data=00`.
- Write `A0+i` to address i for i=0..7, then read 0..7 back to back: expect `rsp_valid` high for 8 consecutive cycles with data A0..A7, each one cycle after its accept.
- Hold `wr_valid` (addr 2, data 55) and `rd_valid` (addr 2) high together: write granted first, read next, and the response returns 55. Continued contention alternates grants.
- Assert `rd_valid` during `INIT`: `rd_ready` stays 0 until `init_done=1`; the read is then accepted in the first `RUN` cycle.
- Pulse `rst_n` low in the cycle after a read accept (memory previously holding A3 at addr 3): `rsp_valid` drops immediately with no response, the sweep restarts, and a later read of addr 3 returns 00.
- Set `wr_valid` and `rd_valid` both low in `RUN`: `ram_en=0`, both readies 0, `rsp_valid` stays 0.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM access controller.
package ram_ctrl_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} ctrl_state_t;

  // One-hot grant: bit 0 = write channel, bit 1 = read channel
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_WR   = 2'b01;
  localparam logic [1:0] GNT_RD   = 2'b10;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; priority flips only on contested cycles.
module rr_arbiter2
  import ram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);
  logic r_prio_rd;

  always_comb begin
    o_gnt = GNT_NONE;
    if (i_en) begin
      case (i_req)
        2'b01:   o_gnt = GNT_WR;
        2'b10:   o_gnt = GNT_RD;
        2'b11:   o_gnt = r_prio_rd ? GNT_RD : GNT_WR;
        default: o_gnt = GNT_NONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_prio_rd <= 1'b0;
    else if (i_en && (&i_req))  r_prio_rd <= ~r_prio_rd;
  end
endmodule

// File: rtl/ram_access_controller.sv
// Single-port RAM front end: zero-fill sweep after reset, then arbitrated
// write/read channels with a 1-cycle read response.
module ram_access_controller
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              init_done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  ctrl_state_t       r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_rsp_valid;
  logic [1:0]        w_gnt;
  logic              w_run;

  // Outputs are gated by rst_n so an asserted reset silences the RAM port at once
  assign w_run = rst_n && (r_state == RUN);

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_run),
    .i_req ({rd_valid, wr_valid}),
    .o_gnt (w_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= INIT;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_rsp_valid <= (w_gnt == GNT_RD);
      if (r_state == INIT) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == LAST) r_state <= RUN;
      end
    end
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    wr_ready  = 1'b0;
    rd_ready  = 1'b0;
    if (rst_n) begin
      if (r_state == INIT) begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = r_cnt;
      end else begin
        case (w_gnt)
          GNT_WR: begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = wr_addr;
            ram_wdata = wr_data;
            wr_ready  = 1'b1;
          end
          GNT_RD: begin
            ram_en   = 1'b1;
            ram_addr = rd_addr;
            rd_ready = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign init_done = (r_state == RUN);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_valid ? ram_rdata : '0;
endmodule

// File: tb/tb_ram_access_controller.sv
// Scoreboard bench for ram_access_controller with a behavioural RAM and reference model.
module tb_ram_access_controller;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid, rd_valid;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready, rd_ready, rsp_valid, init_done;
  logic [DW-1:0] rsp_data;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [DW-1:0] ram_mem [DEPTH] = '{default: 8'hC5};

  always #5 clk = ~clk;

  ram_access_controller #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .init_done(init_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Behavioural single_port_ram: contents survive reset, only the sweep clears them
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model state
  logic [DW-1:0] mdl [DEPTH];
  logic [DW-1:0] expq [$];
  bit            fav_rd;
  bit            prev_rd;
  int            cyc;
  bit            gw, gr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cyc <= 0;
    else if (cyc < 1000)  cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_rd_ready", rd_ready, 0);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_wdata", ram_wdata, 0);
      fav_rd = 0;
      prev_rd = 0;
      expq.delete();
      for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    end else begin
      chk("rsp_valid", rsp_valid, prev_rd);
      if (!rsp_valid) chk("rsp_data_idle", rsp_data, 0);
      if (cyc < DEPTH) begin
        chk("init_done_low", init_done, 0);
        chk("sweep_en", ram_en, 1);
        chk("sweep_we", ram_we, 1);
        chk("sweep_addr", ram_addr, cyc);
        chk("sweep_wdata", ram_wdata, 0);
        chk("init_wr_ready", wr_ready, 0);
        chk("init_rd_ready", rd_ready, 0);
        prev_rd = 0;
      end else begin
        chk("init_done_high", init_done, 1);
        gw = wr_valid && !(rd_valid && fav_rd);
        gr = rd_valid && !gw;
        chk("wr_ready", wr_ready, gw);
        chk("rd_ready", rd_ready, gr);
        chk("ram_en", ram_en, gw || gr);
        if (gw || gr) begin
          chk("ram_we", ram_we, gw);
          chk("ram_addr", ram_addr, gw ? wr_addr : rd_addr);
          chk("ram_wdata", ram_wdata, gw ? wr_data : 8'h00);
        end
        if (wr_valid && rd_valid) fav_rd = !fav_rd;
        if (gw) mdl[wr_addr] = wr_data;
        if (gr) expq.push_back(mdl[rd_addr]);
        prev_rd = gr;
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected at %0t: got %0h expected no response", $time, rsp_data);
      end else begin
        chk("rsp_data", rsp_data, expq.pop_front());
      end
    end
  end

  task automatic drive(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic rv, input logic [AW-1:0] ra);
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_valid = rv; rd_addr = ra;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0;
    wr_valid = 0; rd_valid = 0; wr_addr = '0; rd_addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 3'd5);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) drive(1, AW'(i), 8'hA0 + DW'(i), 0, 0);
    for (int i = 0; i < DEPTH; i++) drive(0, 0, 0, 1, AW'(i));
    repeat (2) drive(0, 0, 0, 0, 0);
    repeat (6) drive(1, 3'd2, 8'h55, 1, 3'd2);
    repeat (3) drive(0, 0, 0, 0, 0);
    repeat (300) begin
      a0 = AW'($urandom_range(0, DEPTH - 1));
      a1 = AW'($urandom_range(0, DEPTH - 1));
      d0 = DW'($urandom);
      drive(1'($urandom_range(0, 1)), a0, d0, 1'($urandom_range(0, 1)), a1);
    end
    drive(1, 3'd3, 8'hA3, 0, 0);
    drive(0, 0, 0, 1, 3'd3);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) drive(0, 0, 0, 1, 3'd3);
    repeat (4) drive(0, 0, 0, 0, 0);
    chk("drain", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
